// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one dual-port register file between requesters A and B, with a zero-fill clear sweep.
// Latency: grant is combinational; read data/RVALID registered 1 cycle after grant. Sweep takes 2^ADDR_SIZE cycles.
// Backpressure: requesters hold REQ until GNT; CLR or an active sweep stalls all grants. Option: RF_SCRUB_ON_RESET_EN.
module regfile_arbiter #(
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic                 A_REQ,
  input  logic                 A_WE,
  input  logic [ADDR_SIZE-1:0] A_ADRX,
  input  logic [ADDR_SIZE-1:0] A_ADRY,
  input  logic [DATA_SIZE-1:0] A_DIN,
  output logic                 A_GNT,
  output logic                 A_RVALID,
  output logic [DATA_SIZE-1:0] A_DX,
  output logic [DATA_SIZE-1:0] A_DY,
  input  logic                 B_REQ,
  input  logic                 B_WE,
  input  logic [ADDR_SIZE-1:0] B_ADRX,
  input  logic [ADDR_SIZE-1:0] B_ADRY,
  input  logic [DATA_SIZE-1:0] B_DIN,
  output logic                 B_GNT,
  output logic                 B_RVALID,
  output logic [DATA_SIZE-1:0] B_DX,
  output logic [DATA_SIZE-1:0] B_DY,
  output logic [ADDR_SIZE-1:0] RAM_ADRX,
  output logic [ADDR_SIZE-1:0] RAM_ADRY,
  output logic [DATA_SIZE-1:0] RAM_DIN,
  output logic                 RAM_WE,
  input  logic [DATA_SIZE-1:0] RAM_DX,
  input  logic [DATA_SIZE-1:0] RAM_DY,
  output logic                 BUSY
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
`ifdef RF_SCRUB_ON_RESET_EN
  localparam logic [0:0] ST_RESET = ST_CLEAR;
`else
  localparam logic [0:0] ST_RESET = ST_ARB;
`endif
  localparam logic [ADDR_SIZE:0] CNT_LAST = {1'b0, {ADDR_SIZE{1'b1}}};

  logic [0:0]       state;
  logic             last_b;
  logic [ADDR_SIZE:0] cnt;
  logic             arb_en;

  // last_b=1 means B won the previous grant, so A wins the next tie
  assign arb_en = (state == ST_ARB) && !CLR;
  assign A_GNT  = arb_en && A_REQ && (!B_REQ || last_b);
  assign B_GNT  = arb_en && B_REQ && (!A_REQ || !last_b);
  assign BUSY   = (state == ST_CLEAR);

  always_comb begin
    RAM_WE   = 1'b0;
    RAM_ADRX = '0;
    RAM_ADRY = '0;
    RAM_DIN  = '0;
    if (state == ST_CLEAR) begin
      RAM_WE   = 1'b1;
      RAM_ADRX = cnt[ADDR_SIZE-1:0];
    end else if (A_GNT) begin
      RAM_WE   = A_WE;
      RAM_ADRX = A_ADRX;
      RAM_ADRY = A_ADRY;
      RAM_DIN  = A_DIN;
    end else if (B_GNT) begin
      RAM_WE   = B_WE;
      RAM_ADRX = B_ADRX;
      RAM_ADRY = B_ADRY;
      RAM_DIN  = B_DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_RESET;
      last_b   <= 1'b1;
      cnt      <= '0;
      A_RVALID <= 1'b0;
      B_RVALID <= 1'b0;
      A_DX     <= '0;
      A_DY     <= '0;
      B_DX     <= '0;
      B_DY     <= '0;
    end else begin
      // async-read RAM gives the pre-write value in the grant cycle
      A_RVALID <= A_GNT;
      B_RVALID <= B_GNT;
      if (A_GNT) begin
        A_DX <= RAM_DX;
        A_DY <= RAM_DY;
      end
      if (B_GNT) begin
        B_DX <= RAM_DX;
        B_DY <= RAM_DY;
      end
      if (A_GNT)
        last_b <= 1'b0;
      else if (B_GNT)
        last_b <= 1'b1;

      case (state)
        ST_ARB: begin
          if (CLR) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          if (CLR) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_ARB;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
